// File: rtl/difftest_pkg.sv
// Shared types and constants for the difftest commit producer.
// Optional memory-trace fields are compiled in with DIFFTEST_MEMTRACE_EN.
package difftest_pkg;

   localparam int XLEN = 64;

   localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

   // One retired instruction as it sits in the replay FIFO
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     inst;
      logic            wen;
      logic [4:0]      waddr;
      logic [XLEN-1:0] wdata;
`ifdef DIFFTEST_MEMTRACE_EN
      logic            mem_req;
      logic            mem_we;
      logic            mem_cached;
      logic [2:0]      mem_size;
      logic [XLEN-1:0] mem_addr;
      logic [XLEN-1:0] mem_data;
`endif
   } commit_entry_t;

endpackage

// File: rtl/commit_fifo.sv
// Two-write / one-read circular buffer of commit entries.
// Up to two entries are written per cycle (wdata0 first, then wdata1);
// flush drops everything, including a push in the same cycle.
module commit_fifo
   import difftest_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          flush_i,
   input  logic [1:0]    push_cnt_i,
   input  commit_entry_t wdata0_i,
   input  commit_entry_t wdata1_i,
   input  logic          pop_i,
   output commit_entry_t head_o,
   output logic          empty_o,
   output logic          free_ge2_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   commit_entry_t mem_q [DEPTH];
   logic [AW-1:0] wptr_q;
   logic [AW-1:0] rptr_q;
   logic [CW-1:0] count_q;

   // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else if (flush_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_q + AW'(push_cnt_i);
         rptr_q  <= rptr_q + AW'(pop_i);
         count_q <= count_q + CW'(push_cnt_i) - CW'(pop_i);
      end
   end

   // Entry storage; contents are only meaningful between rptr and wptr
   always_ff @(posedge clock) begin
      if (!flush_i) begin
         if (push_cnt_i != 2'd0) begin
            mem_q[wptr_q] <= wdata0_i;
         end
         if (push_cnt_i == 2'd2) begin
            mem_q[wptr_q + AW'(1)] <= wdata1_i;
         end
      end
   end

   assign head_o     = mem_q[rptr_q];
   assign empty_o    = (count_q == '0);
   assign free_ge2_o = (count_q <= CW'(DEPTH - 2));

endmodule

// File: rtl/difftest_commit_gen.sv
// Producer side of the difftest commit interface: compacts up to two
// retiring instructions per cycle into a FIFO, replays them one per cycle
// and keeps a shadow GPR file in step with the reported commits.
// Define DIFFTEST_MEMTRACE_EN to carry and report memory-access fields.
module difftest_commit_gen #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 64
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmt0_valid,
   input  logic [XLEN-1:0]   cmt0_pc,
   input  logic [31:0]       cmt0_inst,
   input  logic              cmt0_wen,
   input  logic [4:0]        cmt0_waddr,
   input  logic [XLEN-1:0]   cmt0_wdata,
   input  logic              cmt1_valid,
   input  logic [XLEN-1:0]   cmt1_pc,
   input  logic [31:0]       cmt1_inst,
   input  logic              cmt1_wen,
   input  logic [4:0]        cmt1_waddr,
   input  logic [XLEN-1:0]   cmt1_wdata,
`ifdef DIFFTEST_MEMTRACE_EN
   input  logic              cmt0_mem_req,
   input  logic              cmt0_mem_we,
   input  logic              cmt0_mem_cached,
   input  logic [2:0]        cmt0_mem_size,
   input  logic [XLEN-1:0]   cmt0_mem_addr,
   input  logic [XLEN-1:0]   cmt0_mem_data,
   input  logic              cmt1_mem_req,
   input  logic              cmt1_mem_we,
   input  logic              cmt1_mem_cached,
   input  logic [2:0]        cmt1_mem_size,
   input  logic [XLEN-1:0]   cmt1_mem_addr,
   input  logic [XLEN-1:0]   cmt1_mem_data,
   output logic              mem_req,
   output logic              mem_write_read,
   output logic              mem_cached,
   output logic [2:0]        mem_size,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN-1:0]   mem_data,
   output logic [XLEN-1:0]   mem_pc,
`endif
   output logic              cmt_ready,
   output logic [32*XLEN-1:0] gpr_wire,
   output logic [XLEN-1:0]   pc,
   output logic [XLEN-1:0]   debug_pc,
   output logic              inst_commit,
   output logic              cpu_ebreak_sign
);

   import difftest_pkg::*;

   commit_entry_t slot0, slot1, wr0, wr1, head;
   logic [1:0]    push_cnt;
   logic          empty, free_ge2, pop, is_ebreak;

   logic            halted_q;
   logic            inst_commit_q;
   logic            ebreak_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] debug_pc_q;
   logic [XLEN-1:0] gpr_q [32];

   // Pack each retire slot into a FIFO entry
   always_comb begin
      slot0       = '0;
      slot0.pc    = cmt0_pc;
      slot0.inst  = cmt0_inst;
      slot0.wen   = cmt0_wen;
      slot0.waddr = cmt0_waddr;
      slot0.wdata = cmt0_wdata;
      slot1       = '0;
      slot1.pc    = cmt1_pc;
      slot1.inst  = cmt1_inst;
      slot1.wen   = cmt1_wen;
      slot1.waddr = cmt1_waddr;
      slot1.wdata = cmt1_wdata;
`ifdef DIFFTEST_MEMTRACE_EN
      slot0.mem_req    = cmt0_mem_req;
      slot0.mem_we     = cmt0_mem_we;
      slot0.mem_cached = cmt0_mem_cached;
      slot0.mem_size   = cmt0_mem_size;
      slot0.mem_addr   = cmt0_mem_addr;
      slot0.mem_data   = cmt0_mem_data;
      slot1.mem_req    = cmt1_mem_req;
      slot1.mem_we     = cmt1_mem_we;
      slot1.mem_cached = cmt1_mem_cached;
      slot1.mem_size   = cmt1_mem_size;
      slot1.mem_addr   = cmt1_mem_addr;
      slot1.mem_data   = cmt1_mem_data;
`endif
   end

   // Ready is held low during reset so nothing is accepted before release
   assign cmt_ready = !reset && !halted_q && free_ge2;

   // Compaction: a lone slot-1 commit takes the first write port
   always_comb begin
      push_cnt = 2'd0;
      wr0      = slot0;
      wr1      = slot1;
      if (cmt_ready) begin
         if (cmt0_valid && cmt1_valid) begin
            push_cnt = 2'd2;
         end else if (cmt0_valid) begin
            push_cnt = 2'd1;
         end else if (cmt1_valid) begin
            push_cnt = 2'd1;
            wr0      = slot1;
         end
      end
   end

   assign pop       = !empty && !halted_q;
   assign is_ebreak = pop && (head.inst == EBREAK_INST);

   commit_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .flush_i    (is_ebreak),
      .push_cnt_i (push_cnt),
      .wdata0_i   (wr0),
      .wdata1_i   (wr1),
      .pop_i      (pop),
      .head_o     (head),
      .empty_o    (empty),
      .free_ge2_o (free_ge2)
   );

   // Report the popped entry, update the shadow GPRs and latch the halt
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         halted_q      <= 1'b0;
         inst_commit_q <= 1'b0;
         ebreak_q      <= 1'b0;
         pc_q          <= '0;
         debug_pc_q    <= '0;
         for (int i = 0; i < 32; i++) begin
            gpr_q[i] <= '0;
         end
      end else begin
         inst_commit_q <= pop;
         ebreak_q      <= is_ebreak;
         if (pop) begin
            pc_q       <= head.pc;
            debug_pc_q <= {{(XLEN-32){1'b0}}, head.inst};
            if (head.wen && (head.waddr != 5'd0)) begin
               gpr_q[head.waddr] <= head.wdata;
            end
         end
         if (is_ebreak) begin
            halted_q <= 1'b1;
         end
      end
   end

`ifdef DIFFTEST_MEMTRACE_EN
   // Memory trace of the popped entry; idle cycles report zeros
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mem_req        <= 1'b0;
         mem_write_read <= 1'b0;
         mem_cached     <= 1'b0;
         mem_size       <= '0;
         mem_addr       <= '0;
         mem_data       <= '0;
         mem_pc         <= '0;
      end else if (pop) begin
         mem_req        <= head.mem_req;
         mem_write_read <= head.mem_we;
         mem_cached     <= head.mem_cached;
         mem_size       <= head.mem_size;
         mem_addr       <= head.mem_addr;
         mem_data       <= head.mem_data;
         mem_pc         <= head.pc;
      end else begin
         mem_req        <= 1'b0;
         mem_write_read <= 1'b0;
         mem_cached     <= 1'b0;
         mem_size       <= '0;
         mem_addr       <= '0;
         mem_data       <= '0;
         mem_pc         <= '0;
      end
   end
`endif

   for (genvar g = 0; g < 32; g++) begin : g_gpr_flat
      assign gpr_wire[XLEN*g +: XLEN] = gpr_q[g];
   end

   assign inst_commit     = inst_commit_q;
   assign cpu_ebreak_sign = ebreak_q;
   assign pc              = pc_q;
   assign debug_pc        = debug_pc_q;

endmodule

// File: tb/tb_difftest_commit_gen.sv
// Self-checking bench for difftest_commit_gen: directed scenarios plus a
// randomized run, all compared against a queue-based reference model.
module tb_difftest_commit_gen;

   localparam int DEPTH = 4;
   localparam int XLEN  = 64;
   localparam logic [31:0] EBREAK = 32'h0010_0073;

   logic clock = 1'b0;
   logic reset;
   logic cmt0_valid, cmt1_valid;
   logic [63:0] cmt0_pc, cmt1_pc, cmt0_wdata, cmt1_wdata;
   logic [31:0] cmt0_inst, cmt1_inst;
   logic cmt0_wen, cmt1_wen;
   logic [4:0] cmt0_waddr, cmt1_waddr;
   logic cmt_ready, inst_commit, cpu_ebreak_sign;
   logic [32*XLEN-1:0] gpr_wire;
   logic [63:0] pc, debug_pc;
`ifdef DIFFTEST_MEMTRACE_EN
   logic mReq = 1'b0, mWr, mCached;
   logic [2:0] mSize;
   logic [63:0] mAddr, mData, mPc;
`endif

   always #5 clock = ~clock;

   difftest_commit_gen #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clock(clock), .reset(reset),
      .cmt0_valid(cmt0_valid), .cmt0_pc(cmt0_pc), .cmt0_inst(cmt0_inst),
      .cmt0_wen(cmt0_wen), .cmt0_waddr(cmt0_waddr), .cmt0_wdata(cmt0_wdata),
      .cmt1_valid(cmt1_valid), .cmt1_pc(cmt1_pc), .cmt1_inst(cmt1_inst),
      .cmt1_wen(cmt1_wen), .cmt1_waddr(cmt1_waddr), .cmt1_wdata(cmt1_wdata),
`ifdef DIFFTEST_MEMTRACE_EN
      .cmt0_mem_req(mReq), .cmt0_mem_we(mReq), .cmt0_mem_cached(mReq),
      .cmt0_mem_size(3'd0), .cmt0_mem_addr(64'd0), .cmt0_mem_data(64'd0),
      .cmt1_mem_req(mReq), .cmt1_mem_we(mReq), .cmt1_mem_cached(mReq),
      .cmt1_mem_size(3'd0), .cmt1_mem_addr(64'd0), .cmt1_mem_data(64'd0),
      .mem_req(), .mem_write_read(mWr), .mem_cached(mCached), .mem_size(mSize),
      .mem_addr(mAddr), .mem_data(mData), .mem_pc(mPc),
`endif
      .cmt_ready(cmt_ready), .gpr_wire(gpr_wire), .pc(pc), .debug_pc(debug_pc),
      .inst_commit(inst_commit), .cpu_ebreak_sign(cpu_ebreak_sign)
   );

   typedef struct {
      logic [63:0] pc;
      logic [31:0] inst;
      logic        wen;
      logic [4:0]  waddr;
      logic [63:0] wdata;
   } commit_t;

   commit_t     modelQ[$];
   logic [63:0] modelGpr[32];
   bit          modelHalted;
   bit          expCommit, expEbreak;
   logic [63:0] expPc, expDebugPc;
   int          testsRun = 0;
   int          testsFailed = 0;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   task automatic modelReset();
      modelQ.delete();
      for (int i = 0; i < 32; i++) modelGpr[i] = '0;
      modelHalted = 0;
      expCommit   = 0;
      expEbreak   = 0;
      expPc       = '0;
      expDebugPc  = '0;
   endtask

   task automatic applyStimulus(input int slot, input bit v, input logic [63:0] pcv,
                                input logic [31:0] inst, input bit wen,
                                input logic [4:0] waddr, input logic [63:0] wdata);
      if (slot == 0) begin
         cmt0_valid = v; cmt0_pc = pcv; cmt0_inst = inst;
         cmt0_wen = wen; cmt0_waddr = waddr; cmt0_wdata = wdata;
      end else begin
         cmt1_valid = v; cmt1_pc = pcv; cmt1_inst = inst;
         cmt1_wen = wen; cmt1_waddr = waddr; cmt1_wdata = wdata;
      end
   endtask

   task automatic clearSlots();
      applyStimulus(0, 0, '0, '0, 0, '0, '0);
      applyStimulus(1, 0, '0, '0, 0, '0, '0);
   endtask

   task automatic checkGprs(input string prefix);
      for (int i = 0; i < 32; i++)
         checkOutput($sformatf("%s_gpr%0d", prefix, i), gpr_wire[64*i +: 64], modelGpr[i]);
   endtask

   function automatic bit modelReady();
      return !modelHalted && (DEPTH - modelQ.size()) >= 2;
   endfunction

   // One clock: advance the reference model on the edge, then compare
   task automatic stepCycle();
      commit_t e;
      bit rdy, flushNow;
      @(posedge clock);
      rdy       = modelReady();
      expCommit = 0;
      expEbreak = 0;
      flushNow  = 0;
      if (modelQ.size() > 0 && !modelHalted) begin
         e          = modelQ.pop_front();
         expCommit  = 1;
         expPc      = e.pc;
         expDebugPc = {32'b0, e.inst};
         if (e.wen && e.waddr != 0) modelGpr[e.waddr] = e.wdata;
         if (e.inst == EBREAK) begin
            expEbreak = 1;
            flushNow  = 1;
         end
      end
      if (rdy) begin
         if (cmt0_valid) modelQ.push_back('{cmt0_pc, cmt0_inst, cmt0_wen, cmt0_waddr, cmt0_wdata});
         if (cmt1_valid) modelQ.push_back('{cmt1_pc, cmt1_inst, cmt1_wen, cmt1_waddr, cmt1_wdata});
      end
      if (flushNow) begin
         modelQ.delete();
         modelHalted = 1;
      end
      #1;
      checkOutput("inst_commit", 64'(inst_commit), 64'(expCommit));
      checkOutput("ebreak", 64'(cpu_ebreak_sign), 64'(expEbreak));
      checkOutput("pc", pc, expPc);
      checkOutput("debug_pc", debug_pc, expDebugPc);
      checkOutput("cmt_ready", 64'(cmt_ready), 64'(modelReady()));
      if (expCommit) checkGprs("cycle");
   endtask

   // Assert reset away from an edge; outputs must clear without a clock
   task automatic doReset();
      reset = 1'b1;
      clearSlots();
      #2;
      modelReset();
      checkOutput("rst_commit", 64'(inst_commit), 64'd0);
      checkOutput("rst_ebreak", 64'(cpu_ebreak_sign), 64'd0);
      checkOutput("rst_pc", pc, 64'd0);
      checkOutput("rst_debug_pc", debug_pc, 64'd0);
      checkOutput("rst_ready", 64'(cmt_ready), 64'd0);
      checkGprs("rst");
      @(negedge clock);
      reset = 1'b0;
      #1;
      checkOutput("post_rst_ready", 64'(cmt_ready), 64'd1);
   endtask

   function automatic logic [31:0] randInst();
      logic [31:0] v;
      v = $urandom;
      if (v == EBREAK) v = v ^ 32'h1;
      return v;
   endfunction

   initial begin
      int accepted;
      int guard;
      reset = 1'b1;
      clearSlots();
      modelReset();
      #12;
      doReset();

      // Single commit: x1 <- 5
      applyStimulus(0, 1, 64'h8000_0000, 32'h0050_0093, 1, 5'd1, 64'd5);
      stepCycle();
      clearSlots();
      stepCycle();
      checkOutput("single_x1", gpr_wire[127:64], 64'd5);
      stepCycle();

      // Eight dual-retire pairs, each held until accepted
      accepted = 0;
      guard    = 0;
      while (accepted < 8 && guard < 40) begin
         applyStimulus(0, 1, 64'h1000 + 64'(accepted * 8), randInst(), 1, 5'(accepted + 2), 64'(accepted));
         applyStimulus(1, 1, 64'h1004 + 64'(accepted * 8), randInst(), 1, 5'(accepted + 10), 64'(accepted + 100));
         if (modelReady()) accepted++;
         stepCycle();
         guard++;
      end
      checkOutput("dual_all_accepted", 64'(accepted), 64'd8);
      clearSlots();
      repeat (8) stepCycle();

      // Lone slot-1 commit
      applyStimulus(1, 1, 64'h100, randInst(), 1, 5'd7, 64'h77);
      stepCycle();
      clearSlots();
      repeat (2) stepCycle();
      checkOutput("slot1_pc", pc, 64'h100);

      // Write to x0 is discarded
      applyStimulus(0, 1, 64'h200, randInst(), 1, 5'd0, 64'hDEAD);
      stepCycle();
      clearSlots();
      repeat (2) stepCycle();
      checkOutput("x0_zero", gpr_wire[63:0], 64'd0);

      // Randomized traffic
      for (int c = 0; c < 300; c++) begin
         applyStimulus(0, 1'($urandom_range(0, 1)), {$urandom, $urandom}, randInst(),
                       1'($urandom_range(0, 1)), 5'($urandom), {$urandom, $urandom});
         applyStimulus(1, 1'($urandom_range(0, 1)), {$urandom, $urandom}, randInst(),
                       1'($urandom_range(0, 1)), 5'($urandom), {$urandom, $urandom});
         stepCycle();
      end
      clearSlots();
      repeat (6) stepCycle();

      // Ebreak behind one entry, with younger entries queued behind it
      applyStimulus(0, 1, 64'h300, randInst(), 1, 5'd3, 64'h33);
      applyStimulus(1, 1, 64'h304, randInst(), 1, 5'd4, 64'h44);
      stepCycle();
      applyStimulus(0, 1, 64'h308, EBREAK, 0, 5'd0, 64'd0);
      applyStimulus(1, 1, 64'h30C, randInst(), 1, 5'd5, 64'h55);
      stepCycle();
      for (int c = 0; c < 4; c++) begin
         applyStimulus(0, 1, 64'h400 + 64'(c * 8), randInst(), 1, 5'd6, 64'(c));
         applyStimulus(1, 1, 64'h404 + 64'(c * 8), randInst(), 1, 5'd8, 64'(c));
         stepCycle();
      end
      clearSlots();
      repeat (4) stepCycle();
      checkOutput("halted_ready", 64'(cmt_ready), 64'd0);
      checkOutput("halted_pc", pc, 64'h308);
      doReset();

      // Reset while three entries are buffered
      applyStimulus(0, 1, 64'h500, randInst(), 1, 5'd9, 64'h99);
      applyStimulus(1, 1, 64'h504, randInst(), 1, 5'd10, 64'hAA);
      stepCycle();
      applyStimulus(0, 1, 64'h508, randInst(), 1, 5'd11, 64'hBB);
      applyStimulus(1, 1, 64'h50C, randInst(), 1, 5'd12, 64'hCC);
      stepCycle();
      checkOutput("three_buffered", 64'(modelQ.size()), 64'd3);
      doReset();
      repeat (4) stepCycle();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
